// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/parity/stop recovery with a
// single-entry ready/valid output register, error flags and a sticky overrun.
module uart_rx_deframer #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rxin,
  input  logic                 rdy,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dvalid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Tick thresholds: the start bit is verified half a bit in, every later
  // sample lands one full bit period after the previous one.
  localparam logic [4:0] HALF_LAST = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] FULL_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [1:0] PMODE     = 2'(PARITY_MODE);

  // Parity check: the received parity bit together with the data must have
  // an even (mode 1) or odd (mode 2) number of ones.
  function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] data,
                                           input logic                 sample);
    logic ones_odd;
    ones_odd = (^data) ^ sample;
    case (PMODE)
      2'd1:    return ones_odd;
      2'd2:    return ~ones_odd;
      default: return 1'b0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [4:0]             tick_cnt_q, tick_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   comp_s;

  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   dvalid_q, dvalid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  // Frame FSM next state: everything advances only on baud_tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    comp_s     = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (rxin) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // Falling edge after the line was seen idle: begin a frame with
            // a clean shift register and clean error accumulators.
            state_d    = START;
            armed_d    = 1'b0;
            tick_cnt_d = 5'd0;
            bit_cnt_d  = 4'd0;
            shift_d    = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end else begin
            armed_d = armed_q;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = 5'd0;
            if (rxin) begin
              state_d = IDLE;  // glitch, not a real start bit
            end else begin
              state_d   = DATA;
              bit_cnt_d = 4'd0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = 5'd0;
            shift_d    = {rxin, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = 4'd0;
              state_d   = (PMODE != 2'd0) ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
        PARITY: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = 5'd0;
            perr_d     = calc_parity_err(shift_q, rxin);
            bit_cnt_d  = 4'd0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
        STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = 5'd0;
            ferr_d     = ferr_q | ~rxin;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_d = 4'd0;
              state_d   = IDLE;
              comp_s    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output register next state: deliver, drop-with-overrun, or handshake.
  always_comb begin
    dout_d       = dout_q;
    dvalid_d     = dvalid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    busy_d       = (state_d != IDLE);
    if (comp_s) begin
      if (!dvalid_q || rdy) begin
        dout_d       = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_d;  // includes the stop sample taken this tick
        dvalid_d     = 1'b1;
        // A load that replaces a pending word is also a handshake.
        overrun_d    = dvalid_q ? 1'b0 : overrun_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dvalid_q && rdy) begin
      dvalid_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      dvalid_d = dvalid_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= 5'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dvalid     = dvalid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
